// File: rtl/reg_dump_reader_pkg.sv
// Shared defaults and helpers for the register dump reader and its output buffer.
package reg_dump_reader_pkg;

    localparam int RDR_WIDTH      = 8;
    localparam int RDR_ADDR_WIDTH = 3;
    localparam int FIFO_DEPTH     = 2;

    // Occupancy the buffer reaches once the outstanding read lands and the current pop completes.
    function automatic logic [2:0] projected_fill(
        input logic [1:0] count,
        input logic       inflight,
        input logic       pop
    );
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/reg_dump_reader_sync_fifo2.sv
// Two-entry synchronous FIFO with first-word-fall-through output and occupancy count.
module sync_fifo2
    import reg_dump_reader_pkg::*;
#(
    parameter int width = RDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout,
    output logic [1:0]       count
);

    logic                                 wr_ptr_reg;
    logic                                 rd_ptr_reg;
    logic [1:0]                           count_reg;
    logic [FIFO_DEPTH-1:0][width-1:0]     entries;
    logic                                 do_push;
    logic                                 do_pop;

    assign do_pop  = pop && (count_reg != 2'd0);
    // A push into a full buffer is only legal when the head leaves on the same edge.
    assign do_push = push && ((count_reg != 2'(FIFO_DEPTH)) || do_pop);

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [width-1:0] entry_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                entry_reg <= '0;
            end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                entry_reg <= din;
            end
        end

        assign entries[gi] = entry_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign dout  = entries[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/reg_dump_reader.sv
// Streams a contiguous (wrapping) range of register-file entries out over a valid/ready port.
module reg_dump_reader
    import reg_dump_reader_pkg::*;
#(
    parameter int width      = RDR_WIDTH,
    parameter int addr_width = RDR_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic                  rf_r_en,
    output logic [addr_width-1:0] rf_r_addr,
    input  logic [width-1:0]      rf_r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [width-1:0]      m_data,
    output logic                  m_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [addr_width-1:0] ONE_PTR = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [addr_width:0]   ONE_CNT = {{addr_width{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        DRAIN = ST_DRAIN
    } state_t;

    state_t                state_reg, state_next;
    logic [addr_width-1:0] ptr_reg, ptr_next;
    logic [addr_width:0]   remaining_reg, remaining_next;
    logic [addr_width:0]   out_left_reg, out_left_next;
    logic                  inflight_reg;
    logic                  done_reg, done_next;
    logic                  rd_en;
    logic                  pop;
    logic [1:0]            fifo_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            out_left_reg  <= '0;
            inflight_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            out_left_reg  <= out_left_next;
            inflight_reg  <= rd_en;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        out_left_next  = out_left_reg;
        done_next      = 1'b0;
        rd_en          = 1'b0;

        // out_left counts words not yet accepted, so m_last can be derived from it.
        if (pop) begin
            out_left_next = out_left_reg - ONE_CNT;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_next     = READ;
                        ptr_next       = base_addr;
                        remaining_next = len;
                        out_left_next  = len;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            READ: begin
                // Throttle so the landing read always has a free slot in the buffer.
                if ((remaining_reg != '0) &&
                    (projected_fill(fifo_count, inflight_reg, pop) < 3'(FIFO_DEPTH))) begin
                    rd_en          = 1'b1;
                    ptr_next       = ptr_reg + ONE_PTR;
                    remaining_next = remaining_reg - ONE_CNT;
                    if (remaining_reg == ONE_CNT) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sync_fifo2 #(
        .width (width)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_reg),
        .pop   (pop),
        .din   (rf_r_data),
        .dout  (m_data),
        .count (fifo_count)
    );

    assign m_valid   = (fifo_count != 2'd0);
    assign pop       = m_valid && m_ready;
    assign m_last    = m_valid && (out_left_reg == ONE_CNT);
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign rf_r_en   = rd_en;
    assign rf_r_addr = ptr_reg;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: directed dumps, stalls, wrap, zero length, reset and restart.
module tb_reg_dump_reader;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          rf_r_en;
    logic [AW-1:0] rf_r_addr;
    logic [W-1:0]  rf_r_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;

    int checks       = 0;
    int errors       = 0;
    int done_cnt     = 0;
    int exp_done     = 0;
    int accepted_cnt = 0;
    int outstanding  = 0;
    int cyc          = 0;
    int start_cyc    = 0;

    logic [AW-1:0] addr_q[$];
    logic [W:0]    word_q[$];
    logic          hold_valid = 1'b0;
    logic [W:0]    hold_word  = '0;

    reg_dump_reader #(
        .width      (W),
        .addr_width (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rf_r_en   (rf_r_en),
        .rf_r_addr (rf_r_addr),
        .rf_r_data (rf_r_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rf_val(input logic [AW-1:0] idx);
        case (idx)
            3'd0:    return 8'h3C;
            3'd1:    return 8'hA5;
            3'd2:    return 8'h17;
            3'd3:    return 8'hE2;
            3'd4:    return 8'h68;
            3'd5:    return 8'h9B;
            3'd6:    return 8'h40;
            default: return 8'hD1;
        endcase
    endfunction

    // Register file with one-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_r_en) begin
            rf_r_data <= rf_val(rf_r_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected reads and words as the DUT presents them.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid  = 1'b0;
            outstanding = 0;
        end else begin
            if (hold_valid) begin
                chk("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, hold_word}));
            end
            hold_valid = 1'b0;
            if (m_valid) begin
                if (word_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word: got data 0x%0h last %0b, expected no word", m_data, m_last);
                end else if (m_ready) begin
                    chk("word", 32'({m_last, m_data}), 32'(word_q.pop_front()));
                    accepted_cnt++;
                    outstanding--;
                    $display("word %0d: data=0x%02h last=%0b", accepted_cnt, m_data, m_last);
                end else begin
                    hold_valid = 1'b1;
                    hold_word  = {m_last, m_data};
                end
            end
            if (rf_r_en) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_read: got read of addr %0d, expected no read", rf_r_addr);
                end else begin
                    chk("read_addr", 32'(rf_r_addr), 32'(addr_q.pop_front()));
                end
                outstanding++;
                chk("outstanding_le_2", 32'(outstanding <= 2), 32'd1);
            end
            if (done) begin
                done_cnt++;
            end
        end
    end

    task automatic push_expect(input int b, input int n);
        for (int i = 0; i < n; i++) begin
            addr_q.push_back(AW'((b + i) % 8));
            word_q.push_back({1'(i == n - 1), rf_val(AW'((b + i) % 8))});
        end
        exp_done++;
    endtask

    task automatic run_dump(input int b, input int n, input bit timing);
        push_expect(b, n);
        base_addr = AW'(b);
        len       = (AW + 1)'(n);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        $display("start: base=%0d len=%0d", b, n);
        if (timing) begin
            @(negedge clk);
            chk("first_read_en", 32'(rf_r_en), 32'd1);
            chk("first_read_addr", 32'(rf_r_addr), 32'(b));
            @(negedge clk);
            chk("valid_too_early", 32'(m_valid), 32'd0);
            @(negedge clk);
            chk("first_valid", 32'(m_valid), 32'd1);
        end
    endtask

    task automatic wait_done(input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done in 300 cycles, expected a done pulse");
        end else if (exp_lat > 0) begin
            chk("done_latency", 32'(cyc - start_cyc), 32'(exp_lat));
        end
    endtask

    task automatic finish_dump();
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("leftover_words", 32'(word_q.size()), 32'd0);
        chk("leftover_reads", 32'(addr_q.size()), 32'd0);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rf_r_en"}, 32'(rf_r_en), 32'd0);
        chk({tag, "_rf_r_addr"}, 32'(rf_r_addr), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_last"}, 32'(m_last), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        bit reached;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b1;
        #1;
        check_zero_outputs("reset_async");
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_clocked");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic dump, one word per cycle.
        run_dump(2, 3, 1'b1);
        wait_done(5);
        finish_dump();

        // Address wrap 6,7,0,1.
        @(posedge clk);
        #1;
        run_dump(6, 4, 1'b1);
        wait_done(6);
        finish_dump();

        // Full-range dump with consumer stalled for 5 cycles.
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        run_dump(0, 8, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_done(0);
        finish_dump();

        // Zero-length request.
        @(posedge clk);
        #1;
        base_addr = 3'd5;
        len       = '0;
        start     = 1'b1;
        exp_done++;
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("start: base=5 len=0");
        @(negedge clk);
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        finish_dump();

        // Reset mid-dump after the second word.
        @(posedge clk);
        #1;
        acc0 = accepted_cnt;
        run_dump(3, 5, 1'b0);
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk);
            #1;
            reached = (accepted_cnt >= acc0 + 2);
        end
        chk("reset_test_two_words", 32'(reached), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        addr_q.delete();
        word_q.delete();
        exp_done--;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_no_done", 32'(done_cnt), 32'(exp_done));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_dump(7, 1, 1'b1);
        wait_done(3);
        finish_dump();

        // Start while busy is ignored; start in the done cycle is taken.
        @(posedge clk);
        #1;
        run_dump(0, 3, 1'b0);
        @(negedge clk);
        chk("busy_during_dump", 32'(busy), 32'd1);
        base_addr = 3'd5;
        len       = 4'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0);
        push_expect(4, 2);
        base_addr = 3'd4;
        len       = 4'd2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        $display("start: base=4 len=2 (done cycle)");
        @(negedge clk);
        chk("restart_done_width", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_done(0);
        finish_dump();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 The block SHALL have parameter width, default 8, giving the data width of every register read.
REQ-002 The block SHALL have parameter addr_width, default 3, giving the register-file address width (2^addr_width registers).
REQ-003 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a dump; sampled only in IDLE.
REQ-006 base_addr  input  addr_width  first register address; sampled with start.
REQ-007 len  input  addr_width+1  number of registers to dump, 0..2^addr_width; sampled with start.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 done  output  1  one-cycle pulse when a dump completes.
REQ-010 rf_r_en  output  1  register-file read strobe.
REQ-011 rf_r_addr  output  addr_width  register-file read address.
REQ-012 rf_r_data  input  width  read data, valid exactly one cycle after rf_r_en.
REQ-013 m_valid  output  1  output word valid.
REQ-014 m_ready  input  1  consumer accepts the word when m_valid and m_ready are both high.
REQ-015 m_data  output  width  output word.
REQ-016 m_last  output  1  marks the final word of a dump; valid only while m_valid is high.

Function
REQ-017 The FSM SHALL have states IDLE, READ and DRAIN.
REQ-018 Transition IDLE->READ: on start=1 with len!=0, latching the address pointer = base_addr and remaining = len.
REQ-019 Transition IDLE->IDLE: on start=1 with len=0, pulsing done in the next cycle with no reads and no output words.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 rf_r_en SHALL be high in a cycle iff state=READ, remaining>0 and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
REQ-022 On each rf_r_en, rf_r_addr SHALL equal the pointer; the pointer SHALL then increment modulo 2^addr_width, so 7 wraps to 0 at addr_width=3.
REQ-023 On each rf_r_en, remaining SHALL decrement.
REQ-024 Transition READ->DRAIN: on the cycle the last read is issued (remaining becomes 0).
REQ-025 rf_r_data SHALL be written into a 2-entry FIFO on the edge one cycle after the matching rf_r_en.
REQ-026 The FIFO SHALL never overflow.
REQ-027 Timing: with start high before edge k, rf_r_en/rf_r_addr=base_addr SHALL be high between edges k and k+1, and m_valid SHALL first be high after edge k+2.
REQ-028 With m_ready held high, throughput SHALL be one word per cycle.
REQ-029 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable, and m_valid SHALL not drop.
REQ-030 Words SHALL leave in issue order.
REQ-031 m_last SHALL be high only on the len-th word.
REQ-032 Transition DRAIN->IDLE: on the edge where the m_last word is accepted; done SHALL pulse in the following cycle and busy SHALL be low in that same cycle.
REQ-033 A new start SHALL be accepted in the cycle done is high.
REQ-034 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.

Reset
REQ-035 While rst_n=0, regardless of clk, the block SHALL force: state IDLE; FIFO empty; inflight=0; pointer=0; remaining=0.
REQ-036 While rst_n=0, the block SHALL drive outputs busy, done, rf_r_en, m_valid and m_last to 0, and m_data and rf_r_addr to 0.
REQ-037 Reset asserted mid-dump SHALL abandon the dump without a done pulse, and a read in flight SHALL be discarded.
REQ-038 Reset deassertion SHALL take effect at the next posedge clk.

Structure
REQ-039 State encodings SHALL be localparams inside reg_dump_reader; no shared package is required, and width/addr_width defaults SHALL match the codebase register block (width=8).
REQ-040 The 2-entry buffer SHALL be a sub-module named sync_fifo2 (parameter width; push, pop, din, dout, count), with the same clk/rst_n convention.

Verification
REQ-041 Reset then start with base_addr=2 and len=3 and m_ready=1 -> rf_r_addr 2,3,4 on consecutive cycles; m_data=RF[2],RF[3],RF[4]; m_last on the 3rd word; one done pulse.
REQ-042 base_addr=6, len=4, addr_width=3 -> read addresses 6,7,0,1, and m_last on the RF[1] word.
REQ-043 len=8 with m_ready low for 5 cycles, then high -> at most 2 reads outstanding while stalled, m_data stable, all 8 words in order, with no loss or duplicate.
REQ-044 start with len=0 -> no rf_r_en and no m_valid, done high for exactly one cycle after the start edge.
REQ-045 Assert rst_n=0 after the 2nd word of a len=5 dump -> all outputs 0 immediately, no done; a subsequent start with len=1 completes normally.
REQ-046 Pulse start while busy, then pulse start again in the done cycle -> the busy-time start is ignored and the done-cycle start launches a new dump.
